or1200_enc_load_xor: RTL and testbench

Decrypt stage on the encrypted load path. It sits directly downstream of the load-side pad shifter and consumes its 32-bit shifted pad. It pairs the pad with the matching data-cache read word in whichever order the two arrive, XORs them, and extracts and extends the addressed byte, halfword or word. It returns the plaintext to the LSU with a one-cycle ack and holds the pipeline stall while the load is outstanding.

---
 rtl/or1200_enc_load_xor_if.sv | 26 ++
 rtl/or1200_enc_load_xor.sv | 211 +++++++++++++++++++++
 tb/tb_or1200_enc_load_xor.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/or1200_enc_load_xor_if.sv
// Load-path decrypt bus: LSU request, pad shifter and data-cache inputs,
// and the plaintext result, stall and timeout outputs.
interface or1200_enc_load_xor_if;
    logic        load_start;
    logic [3:0]  lsu_op;
    logic [1:0]  addr_lo;
    logic [31:0] pad;
    logic        pad_valid;
    logic [31:0] dc_dat;
    logic        dc_ack;
    logic        flush;
    logic [31:0] dat;
    logic        ack;
    logic        stall;
    logic        err;

    modport master (
        output load_start, lsu_op, addr_lo, pad, pad_valid, dc_dat, dc_ack, flush,
        input  dat, ack, stall, err
    );

    modport slave (
        input  load_start, lsu_op, addr_lo, pad, pad_valid, dc_dat, dc_ack, flush,
        output dat, ack, stall, err
    );
endinterface

// File: rtl/or1200_enc_load_xor.sv
// Encrypted-load decrypt stage: pairs pad and cache word, XORs, extracts/extends.
// Optional wait timeout enabled by defining OR1200_ENC_XOR_TIMEOUT_EN.
module or1200_enc_load_xor #(
    parameter int TO_CYCLES = 255,
    parameter int TO_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    or1200_enc_load_xor_if.slave   bus
);

    // state      | meaning
    // S_IDLE     | no load outstanding
    // S_WAIT_BOTH| load issued, neither pad nor data held
    // S_WAIT_PAD | data word held, waiting for the pad
    // S_WAIT_DATA| pad held, waiting for the data word
    // S_DONE     | result registered, ack pulses this cycle
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BOTH,
        S_WAIT_PAD,
        S_WAIT_DATA,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_LBZ = 4'b0100;
    localparam logic [3:0] OP_LBS = 4'b0101;
    localparam logic [3:0] OP_LHZ = 4'b0110;
    localparam logic [3:0] OP_LHS = 4'b0111;

    if ((2 ** TO_W) <= TO_CYCLES) begin : g_bad_to_w
        $error("TO_W too narrow for TO_CYCLES");
    end

    state_t      state_q, state_nx;
    logic [3:0]  op_q, op_nx;
    logic [1:0]  addr_q, addr_nx;
    logic [31:0] pad_q, pad_nx;
    logic [31:0] data_q, data_nx;
    logic [31:0] dat_q, dat_nx;
    logic        err_q, err_nx;

    logic        waiting;
    logic        active;
    logic        have_pad;
    logic        have_data;
    logic        pad_take;
    logic        data_take;
    logic        expire;

    function automatic logic [31:0] extract(input logic [31:0] w,
                                            input logic [3:0]  op,
                                            input logic [1:0]  a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        // Big-endian lanes: offset 0 is the most significant byte.
        case (a)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = a[1] ? w[15:0] : w[31:16];
        case (op)
            OP_LBZ:  r = {24'h0, b};
            OP_LBS:  r = {{24{b[7]}}, b};
            OP_LHZ:  r = {16'h0, h};
            OP_LHS:  r = {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign waiting = (state_q == S_WAIT_BOTH) || (state_q == S_WAIT_PAD) ||
                     (state_q == S_WAIT_DATA);

`ifdef OR1200_ENC_XOR_TIMEOUT_EN
    logic [TO_W-1:0] to_q, to_nx;

    always_comb begin
        to_nx = '0;
        if (waiting) begin
            to_nx = to_q + 1'b1;
        end
    end

    assign expire = waiting && (to_q == TO_W'(TO_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_q <= '0;
        end else begin
            to_q <= to_nx;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_nx  = state_q;
        op_nx     = op_q;
        addr_nx   = addr_q;
        pad_nx    = pad_q;
        data_nx   = data_q;
        dat_nx    = dat_q;
        err_nx    = 1'b0;
        active    = 1'b0;
        have_pad  = 1'b0;
        have_data = 1'b0;
        pad_take  = 1'b0;
        data_take = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.load_start) begin
                    active    = 1'b1;
                    op_nx     = bus.lsu_op;
                    addr_nx   = bus.addr_lo;
                    pad_take  = bus.pad_valid;
                    data_take = bus.dc_ack;
                end
            end
            S_WAIT_BOTH: begin
                active    = 1'b1;
                pad_take  = bus.pad_valid;
                data_take = bus.dc_ack;
            end
            S_WAIT_PAD: begin
                active    = 1'b1;
                have_data = 1'b1;
                pad_take  = bus.pad_valid;
            end
            S_WAIT_DATA: begin
                active    = 1'b1;
                have_pad  = 1'b1;
                data_take = bus.dc_ack;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // A repeated strobe for an already-held item never reaches *_take.
        if (pad_take) begin
            pad_nx   = bus.pad;
            have_pad = 1'b1;
        end
        if (data_take) begin
            data_nx   = bus.dc_dat;
            have_data = 1'b1;
        end

        if (active) begin
            if (have_pad && have_data) begin
                state_nx = S_DONE;
                dat_nx   = extract(pad_nx ^ data_nx, op_nx, addr_nx);
            end else if (expire) begin
                state_nx = S_DONE;
                dat_nx   = '0;
                err_nx   = 1'b1;
            end else if (have_pad) begin
                state_nx = S_WAIT_DATA;
            end else if (have_data) begin
                state_nx = S_WAIT_PAD;
            end else begin
                state_nx = S_WAIT_BOTH;
            end
        end

        if (bus.flush) begin
            state_nx = S_IDLE;
            dat_nx   = dat_q;
            err_nx   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            pad_q   <= '0;
            data_q  <= '0;
            dat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nx;
            op_q    <= op_nx;
            addr_q  <= addr_nx;
            pad_q   <= pad_nx;
            data_q  <= data_nx;
            dat_q   <= dat_nx;
            err_q   <= err_nx;
        end
    end

    assign bus.dat   = dat_q;
    assign bus.ack   = (state_q == S_DONE);
    assign bus.stall = ((state_q == S_IDLE) && bus.load_start) || waiting;
`ifdef OR1200_ENC_XOR_TIMEOUT_EN
    assign bus.err   = err_q && (state_q == S_DONE);
`else
    assign bus.err   = 1'b0;
`endif

endmodule

// File: tb/tb_or1200_enc_load_xor.sv
// Directed bench for or1200_enc_load_xor; timeout cases follow OR1200_ENC_XOR_TIMEOUT_EN.
module tb_or1200_enc_load_xor;

    localparam logic [3:0] LBZ = 4'b0100;
    localparam logic [3:0] LBS = 4'b0101;
    localparam logic [3:0] LHZ = 4'b0110;
    localparam logic [3:0] LHS = 4'b0111;
    localparam logic [3:0] LWZ = 4'b1000;
`ifdef OR1200_ENC_XOR_TIMEOUT_EN
    localparam int TO_C = 4;
`else
    localparam int TO_C = 255;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    or1200_enc_load_xor_if bus ();

    or1200_enc_load_xor #(.TO_CYCLES(TO_C), .TO_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic clear_pulses;
        bus.load_start = 1'b0;
        bus.pad_valid  = 1'b0;
        bus.dc_ack     = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        clear_pulses();
    endtask

    task automatic start_load(input logic [3:0] op, input logic [1:0] a);
        bus.load_start = 1'b1;
        bus.lsu_op     = op;
        bus.addr_lo    = a;
    endtask

    task automatic give_pad(input logic [31:0] p);
        bus.pad       = p;
        bus.pad_valid = 1'b1;
    endtask

    task automatic give_data(input logic [31:0] d);
        bus.dc_dat = d;
        bus.dc_ack = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        clear_pulses();
        bus.lsu_op  = 4'h0;
        bus.addr_lo = 2'd0;
        bus.pad     = 32'h0;
        bus.dc_dat  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.ack !== 1'b0 || bus.err !== 1'b0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ack=%b err=%b stall=%b required 0 0 0", bus.ack, bus.err, bus.stall);
        end
        checks++;
        if (bus.dat !== 32'h0) begin
            errors++;
            $display("FAIL reset_dat: got %h required 00000000", bus.dat);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_same_cycle;
        step();
        start_load(LWZ, 2'd0);
        give_pad(32'hA5A5A5A5);
        give_data(32'h0F0F0F0F);
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b1 || bus.ack !== 1'b0) begin
            errors++;
            $display("FAIL same_n: stall=%b ack=%b required 1 0", bus.stall, bus.ack);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b1 || bus.stall !== 1'b0 || bus.dat !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL same_n1: ack=%b stall=%b dat=%h required 1 0 aaaaaaaa", bus.ack, bus.stall, bus.dat);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b0 || bus.dat !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL same_n2: ack=%b dat=%h required 0 aaaaaaaa", bus.ack, bus.dat);
        end
    endtask

    // LBS offset 1: w = 0x00FE0000, byte 0xFE sign-extends
    task automatic test_data_first;
        step();
        start_load(LBS, 2'd1);
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL df_stall_n: got %b required 1", bus.stall);
        end
        step();
        give_data(32'h00FF0000);
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) give_pad(32'h00010000);
            @(negedge clk);
            checks++;
            if (bus.stall !== 1'b1 || bus.ack !== 1'b0) begin
                errors++;
                $display("FAIL df_wait_n%0d: stall=%b ack=%b required 1 0", i, bus.stall, bus.ack);
            end
            if (i < 4) step();
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b1 || bus.stall !== 1'b0 || bus.dat !== 32'hFFFFFFFE) begin
            errors++;
            $display("FAIL df_result: ack=%b stall=%b dat=%h required 1 0 fffffffe", bus.ack, bus.stall, bus.dat);
        end
    endtask

    task automatic test_pad_first;
        step();
        start_load(LHZ, 2'd2);
        step();
        give_pad(32'h0000FFFF);
        step();
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b1 || bus.ack !== 1'b0) begin
            errors++;
            $display("FAIL pf_wait: stall=%b ack=%b required 1 0", bus.stall, bus.ack);
        end
        step();
        give_data(32'h12341234);
        step();
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b1 || bus.dat !== 32'h0000EDCB) begin
            errors++;
            $display("FAIL pf_result: ack=%b dat=%h required 1 0000edcb", bus.ack, bus.dat);
        end
    endtask

    task automatic test_duplicate_stray;
        // stray strobes in IDLE must not be captured
        step();
        give_data(32'hDEADBEEF);
        give_pad(32'h12345678);
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL stray_stall: got %b required 0", bus.stall);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack: got %b required 0", bus.ack);
        end
        step();
        start_load(LWZ, 2'd0);
        step();
        give_pad(32'h11111111);
        step();
        give_pad(32'h22222222);
        step();
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b1 || bus.ack !== 1'b0) begin
            errors++;
            $display("FAIL dup_wait: stall=%b ack=%b required 1 0", bus.stall, bus.ack);
        end
        give_data(32'h33333333);
        step();
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b1 || bus.dat !== 32'h22222222) begin
            errors++;
            $display("FAIL dup_result: ack=%b dat=%h required 1 22222222", bus.ack, bus.dat);
        end
    endtask

    task automatic test_flush;
        step();
        start_load(LWZ, 2'd0);
        step();
        give_data(32'hCAFEF00D);
        step();
        bus.flush = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0 || bus.ack !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: stall=%b ack=%b required 0 0", bus.stall, bus.ack);
        end
        give_pad(32'h0);
        give_data(32'h0);
        step();
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b0 || bus.dat !== 32'h22222222) begin
            errors++;
            $display("FAIL flush_late: ack=%b dat=%h required 0 22222222", bus.ack, bus.dat);
        end
        // flush with load_start drops the new load
        start_load(LWZ, 2'd0);
        give_pad(32'hFFFF0000);
        give_data(32'h0000FFFF);
        bus.flush = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_start: ack=%b stall=%b required 0 0", bus.ack, bus.stall);
        end
    endtask

    task automatic test_back_to_back;
        step();
        start_load(LBZ, 2'd3);
        give_pad(32'h00000000);
        give_data(32'h000000C3);
        step();
        start_load(LWZ, 2'd0);
        give_pad(32'h0);
        give_data(32'h0);
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b1 || bus.stall !== 1'b0 || bus.dat !== 32'h000000C3) begin
            errors++;
            $display("FAIL b2b_first: ack=%b stall=%b dat=%h required 1 0 000000c3", bus.ack, bus.stall, bus.dat);
        end
        step();
        start_load(LHS, 2'd0);
        give_pad(32'h80000000);
        give_data(32'h00010000);
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b0 || bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done_start: ack=%b stall=%b required 0 1", bus.ack, bus.stall);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b1 || bus.dat !== 32'hFFFF8001) begin
            errors++;
            $display("FAIL b2b_second: ack=%b dat=%h required 1 ffff8001", bus.ack, bus.dat);
        end
        // load_start while waiting must not replace the op in flight
        step();
        start_load(LWZ, 2'd0);
        step();
        start_load(LBZ, 2'd0);
        give_pad(32'h0000FF00);
        give_data(32'h00001200);
        step();
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b1 || bus.dat !== 32'h0000ED00) begin
            errors++;
            $display("FAIL b2b_late_start: ack=%b dat=%h required 1 0000ed00", bus.ack, bus.dat);
        end
    endtask

    task automatic test_reset_mid_load;
        step();
        start_load(LWZ, 2'd0);
        step();
        give_data(32'h55555555);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.ack !== 1'b0 || bus.dat !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: stall=%b ack=%b dat=%h required 0 0 00000000", bus.stall, bus.ack, bus.dat);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        give_pad(32'h0);
        step();
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: ack=%b stall=%b required 0 0", bus.ack, bus.stall);
        end
    endtask

    task automatic test_timeout;
`ifdef OR1200_ENC_XOR_TIMEOUT_EN
        step();
        start_load(LWZ, 2'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            @(negedge clk);
            checks++;
            if (bus.ack !== 1'b0 || bus.err !== 1'b0 || bus.stall !== 1'b1) begin
                errors++;
                $display("FAIL to_wait_n%0d: ack=%b err=%b stall=%b required 0 0 1", i, bus.ack, bus.err, bus.stall);
            end
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b1 || bus.err !== 1'b1 || bus.dat !== 32'h0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL to_expire: ack=%b err=%b dat=%h stall=%b required 1 1 00000000 0", bus.ack, bus.err, bus.dat, bus.stall);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL to_after: ack=%b err=%b required 0 0", bus.ack, bus.err);
        end
`else
        int bad;
        bad = 0;
        step();
        start_load(LWZ, 2'd0);
        for (int i = 1; i <= 120; i++) begin
            step();
            @(negedge clk);
            checks++;
            if (bus.stall !== 1'b1 || bus.ack !== 1'b0 || bus.err !== 1'b0) begin
                errors++;
                bad++;
                if (bad <= 3) begin
                    $display("FAIL no_to_wait_n%0d: stall=%b ack=%b err=%b required 1 0 0", i, bus.stall, bus.ack, bus.err);
                end
            end
        end
        step();
        bus.flush = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0 || bus.ack !== 1'b0) begin
            errors++;
            $display("FAIL no_to_flush: stall=%b ack=%b required 0 0", bus.stall, bus.ack);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_data_first();
        test_pad_first();
        test_duplicate_stray();
        test_flush();
        test_back_to_back();
        test_timeout();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
